// File: rtl/mux_4_scan_ctrl.sv
// Steps the 4:1 mux select through channels 0..3, holding each for HOLD_CYCLES clocks,
// and captures one mux_out bit per channel; frame_valid pulses 4*HOLD_CYCLES clocks after start.
module mux_4_scan_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_continuous,
    input  logic       i_abort,
    input  logic       i_mux_out,
    output logic [1:0] o_sel,
    output logic       o_busy,
    output logic       o_frame_valid,
    output logic [3:0] o_sample_data
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_frame_valid;
    logic [3:0]       r_sample_data;
    logic [3:0]       r_capture;

    state_t           w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_busy_nxt;
    logic             w_frame_valid_nxt;
    logic [3:0]       w_sample_data_nxt;
    logic [3:0]       w_capture_nxt;
    logic             w_win_end;

    assign w_win_end = (r_cnt == LAST_CNT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_sel         <= 2'd0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_sample_data <= 4'd0;
            r_capture     <= 4'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_cnt         <= w_cnt_nxt;
            r_busy        <= w_busy_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sample_data <= w_sample_data_nxt;
            r_capture     <= w_capture_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_cnt_nxt         = r_cnt;
        w_busy_nxt        = r_busy;
        w_frame_valid_nxt = 1'b0;
        w_sample_data_nxt = r_sample_data;
        w_capture_nxt     = r_capture;

        case (r_state)
            IDLE: begin
                w_sel_nxt  = 2'd0;
                w_busy_nxt = 1'b0;
                if (i_start && !i_abort) begin
                    w_state_nxt = SCAN;
                    w_sel_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            SCAN: begin
                if (i_abort) begin
                    // Abort discards the partial frame entirely, including on the frame-end edge.
                    w_state_nxt   = IDLE;
                    w_sel_nxt     = 2'd0;
                    w_cnt_nxt     = '0;
                    w_busy_nxt    = 1'b0;
                    w_capture_nxt = 4'd0;
                end else if (w_win_end) begin
                    w_capture_nxt[r_sel] = i_mux_out;
                    w_cnt_nxt            = '0;
                    if (r_sel != 2'd3) begin
                        w_sel_nxt = r_sel + 2'd1;
                    end else begin
                        w_sample_data_nxt = {i_mux_out, r_capture[2:0]};
                        w_frame_valid_nxt = 1'b1;
                        w_sel_nxt         = 2'd0;
                        if (!i_continuous) begin
                            w_state_nxt = IDLE;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = 2'd0;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign o_sel         = r_sel;
    assign o_busy        = r_busy;
    assign o_frame_valid = r_frame_valid;
    assign o_sample_data = r_sample_data;

endmodule

// File: tb/tb_mux_4_scan_ctrl.sv
// Bench for mux_4_scan_ctrl: three instances (HOLD_CYCLES 4, 2, 1) against an elapsed-time model.
module tb_mux_4_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] start;
    logic [2:0] cont;
    logic [2:0] abort;
    logic [3:0] mux_in [3];
    logic [2:0] mux_out;
    logic [1:0] sel_o  [3];
    logic [2:0] busy_o;
    logic [2:0] fv_o;
    logic [3:0] data_o [3];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_en = 0;

    function automatic int hold_of(int g);
        return (g == 0) ? 4 : (g == 1) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign mux_out[g] = mux_in[g][sel_o[g]];
        mux_4_scan_ctrl #(
            .HOLD_CYCLES((g == 0) ? 4 : (g == 1) ? 2 : 1),
            .CNT_W(8)
        ) u_dut (
            .i_clk         (clk),
            .i_reset       (rst),
            .i_start       (start[g]),
            .i_continuous  (cont[g]),
            .i_abort       (abort[g]),
            .i_mux_out     (mux_out[g]),
            .o_sel         (sel_o[g]),
            .o_busy        (busy_o[g]),
            .o_frame_valid (fv_o[g]),
            .o_sample_data (data_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: a scan is just "k clocks since the start edge"; channel = k / H, and a frame
    // completes when k reaches 4*H-1.
    int         m_k    [3];
    bit         m_act  [3];
    bit         m_fv   [3];
    logic [3:0] m_cap  [3];
    logic [3:0] m_data [3];

    always @(posedge clk) begin : model
        int k, h, ch;
        bit act, fv;
        logic [3:0] cap, data;
        for (int g = 0; g < 3; g++) begin
            h = hold_of(g); k = m_k[g]; act = m_act[g]; cap = m_cap[g]; data = m_data[g]; fv = 0;
            if (rst) begin
                k = 0; act = 0; cap = 0; data = 0;
            end else if (!act) begin
                if (start[g] && !abort[g]) begin act = 1; k = 0; end
            end else if (abort[g]) begin
                act = 0; k = 0; cap = 0;
            end else begin
                ch = k / h;
                if (k % h == h - 1) cap[ch] = mux_in[g][ch];
                if (k == 4 * h - 1) begin
                    data = cap; fv = 1; k = 0;
                    if (!cont[g]) act = 0;
                end else begin
                    k++;
                end
            end
            m_k[g] <= k; m_act[g] <= act; m_fv[g] <= fv; m_cap[g] <= cap; m_data[g] <= data;
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (chk_en) begin
            for (int g = 0; g < 3; g++) begin
                check($sformatf("sel%0d", g),  32'(sel_o[g]),  m_act[g] ? 32'(m_k[g] / hold_of(g)) : 32'd0);
                check($sformatf("busy%0d", g), 32'(busy_o[g]), 32'(m_act[g]));
                check($sformatf("fv%0d", g),   32'(fv_o[g]),   32'(m_fv[g]));
                check($sformatf("data%0d", g), 32'(data_o[g]), 32'(m_data[g]));
            end
        end
    end

    task automatic pulse_start(int g, output int s);
        @(negedge clk);
        start[g] = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_fv(int g, int maxc, output int at);
        at = -1000;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if (fv_o[g]) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin : stim
        int s, at;
        rst = 1'b1; start = '0; cont = '0; abort = '0;
        for (int g = 0; g < 3; g++) mux_in[g] = 4'd0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_sel%0d", g),  32'(sel_o[g]),  32'd0);
            check($sformatf("rst_busy%0d", g), 32'(busy_o[g]), 32'd0);
            check($sformatf("rst_data%0d", g), 32'(data_o[g]), 32'd0);
        end
        @(negedge clk); rst = 1'b0;

        // Basic frame, H=4, a=0 b=1 c=0 d=1
        mux_in[0] = 4'b1010;
        pulse_start(0, s);
        wait_fv(0, 40, at);
        check("basic_lat",  32'(at - s), 32'd16);
        check("basic_data", 32'(data_o[0]), 32'b1010);
        check("basic_busy", 32'(busy_o[0]), 32'd0);
        check("basic_sel",  32'(sel_o[0]), 32'd0);

        // Continuous, H=2
        mux_in[1] = 4'b0101;
        cont[1] = 1'b1;
        pulse_start(1, s);
        wait_fv(1, 30, at);
        check("cont1_lat",  32'(at - s), 32'd8);
        check("cont1_data", 32'(data_o[1]), 32'b0101);
        @(negedge clk); mux_in[1] = 4'b1010;
        wait_fv(1, 30, at);
        check("cont2_lat",  32'(at - s), 32'd16);
        check("cont2_data", 32'(data_o[1]), 32'b1010);
        @(negedge clk); cont[1] = 1'b0;
        wait_fv(1, 30, at);
        check("cont3_lat",  32'(at - s), 32'd24);
        check("cont3_busy", 32'(busy_o[1]), 32'd0);

        // Abort while sel==2
        mux_in[0] = 4'b0101;
        pulse_start(0, s);
        repeat (9) @(negedge clk);
        check("abort_presel", 32'(sel_o[0]), 32'd2);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy_o[0]), 32'd0);
        check("abort_sel",  32'(sel_o[0]), 32'd0);
        check("abort_fv",   32'(fv_o[0]), 32'd0);
        check("abort_data", 32'(data_o[0]), 32'b1010);
        @(negedge clk); abort[0] = 1'b0;
        repeat (20) @(negedge clk);

        // Start pulses while busy are ignored
        mux_in[0] = 4'b0110;
        pulse_start(0, s);
        repeat (2) @(negedge clk);
        start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
        repeat (6) @(negedge clk);
        start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
        wait_fv(0, 30, at);
        check("busy_start_lat",  32'(at - s), 32'd16);
        check("busy_start_data", 32'(data_o[0]), 32'b0110);
        repeat (20) @(negedge clk);

        // Reset mid-scan while sel==1
        mux_in[0] = 4'b0011;
        pulse_start(0, s);
        repeat (4) @(negedge clk);
        check("rst_mid_presel", 32'(sel_o[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_sel",  32'(sel_o[0]), 32'd0);
        check("rst_mid_busy", 32'(busy_o[0]), 32'd0);
        check("rst_mid_fv",   32'(fv_o[0]), 32'd0);
        check("rst_mid_data", 32'(data_o[0]), 32'd0);
        @(negedge clk); rst = 1'b0;
        mux_in[0] = 4'b1100;
        pulse_start(0, s);
        wait_fv(0, 30, at);
        check("rst_fresh_lat",  32'(at - s), 32'd16);
        check("rst_fresh_data", 32'(data_o[0]), 32'b1100);

        // H=1 edge cases
        mux_in[2] = 4'b1111;
        pulse_start(2, s);
        wait_fv(2, 10, at);
        check("h1_lat",  32'(at - s), 32'd4);
        check("h1_data", 32'(data_o[2]), 32'b1111);
        mux_in[2] = 4'b0000;
        pulse_start(2, s);
        repeat (3) @(negedge clk);
        abort[2] = 1'b1;
        @(posedge clk); #1;
        check("h1_abort_end_fv",   32'(fv_o[2]), 32'd0);
        check("h1_abort_end_data", 32'(data_o[2]), 32'b1111);
        check("h1_abort_end_busy", 32'(busy_o[2]), 32'd0);
        @(negedge clk); abort[2] = 1'b1; start[2] = 1'b1;
        @(posedge clk); #1;
        check("abort_over_start", 32'(busy_o[2]), 32'd0);
        @(negedge clk); abort[2] = 1'b0; start[2] = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
